// File: rtl/heatmap_pkg.sv
// Shared definitions for the heat-map pixel path: screen/cell geometry
// defaults, iterator state encoding, RGB332 temperature palette and the
// linear pixel-address helper.
package heatmap_pkg;

  localparam int HM_H_RES      = 640;
  localparam int HM_V_RES      = 480;
  localparam int HM_CELL_SHIFT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PRESENT,
    ST_NEXT,
    ST_DONE
  } iter_state_t;

  // Cold-to-hot bands: blue, cyan, green, yellow, orange, red, white.
  localparam logic [7:0] PALETTE [8] = '{
    8'h02, 8'h03, 8'h1F, 8'h1C, 8'hFC, 8'hF4, 8'hE0, 8'hFF
  };

  // Byte address of pixel (x, y) in a row-major frame buffer.
  function automatic logic [31:0] pixel_addr(input logic [15:0] x,
                                              input logic [15:0] y,
                                              input int unsigned h_res);
    return 32'(y) * 32'(h_res) + 32'(x);
  endfunction

endpackage

// File: rtl/heat_pixel_iter_if.sv
// Arbiter / temperature-grid side bus of one pixel iterator.
// master = iterator, slave = arbiter plus grid memory.
// Address/colour are qualified by inter_select; comp_flag completes a pixel.
interface heat_pixel_iter_if #(
  parameter int TEMP_W  = 16,
  parameter int TADDR_W = 13
);

  logic               inter_start;
  logic               comp_flag;
  logic               inter_select;
  logic               inter_done;
  logic [31:0]        vga_addr;
  logic [31:0]        vga_pxl_clr;
  logic               temp_rd;
  logic [TADDR_W-1:0] temp_addr;
  logic [TEMP_W-1:0]  temp_rdata;

  modport master (
    input  inter_start, comp_flag, temp_rdata,
    output inter_select, inter_done, vga_addr, vga_pxl_clr, temp_rd, temp_addr
  );

  modport slave (
    output inter_start, comp_flag, temp_rdata,
    input  inter_select, inter_done, vga_addr, vga_pxl_clr, temp_rd, temp_addr
  );

endinterface

// File: rtl/heat_palette.sv
// Temperature band (3 MSBs of a grid word) to RGB332 colour lookup.
// Latency: combinational.
// Backpressure: none; pure function, also used by the legend generator.
module heat_palette
  import heatmap_pkg::*;
(
  input  logic [2:0] band_i,
  output logic [7:0] clr_o
);

  assign clr_o = PALETTE[band_i];

endmodule

// File: rtl/heat_pixel_iter.sv
// Walks rows ITER_ID, ITER_ID+N_ITER, ... and offers each pixel's address and
// palette colour to the arbiter. Latency: 4 cycles per grid fetch, 2 per
// reused-colour pixel. Backpressure: holds the offer until comp_flag.
module heat_pixel_iter
  import heatmap_pkg::*;
#(
  parameter int ITER_ID    = 0,
  parameter int N_ITER     = 7,
  parameter int H_RES      = HM_H_RES,
  parameter int V_RES      = HM_V_RES,
  parameter int CELL_SHIFT = HM_CELL_SHIFT,
  parameter int TEMP_W     = 16,
  parameter int TADDR_W    = 13
) (
  input  logic              clk,
  input  logic              reset,
  heat_pixel_iter_if.master bus
);

  localparam logic [15:0] X_LAST  = 16'(H_RES - 1);
  localparam logic [15:0] Y_FIRST = 16'(ITER_ID);
  localparam logic [16:0] Y_STEP  = 17'(N_ITER);
  localparam logic [16:0] Y_LIMIT = 17'(V_RES);
  localparam logic [31:0] CELLS_X = 32'(H_RES >> CELL_SHIFT);

  iter_state_t state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [7:0]  clr_q, clr_d;
  logic [31:0] addr_q, addr_d;
  logic        sel_q, sel_d;
  logic        done_q, done_d;
  logic        rd;
  logic [7:0]  band_clr;
  logic [16:0] y_next;

  heat_palette u_palette (
    .band_i (bus.temp_rdata[TEMP_W-1 -: 3]),
    .clr_o  (band_clr)
  );

  assign y_next = {1'b0, y_q} + Y_STEP;

  // Grid cell under the current pixel; only meaningful while fetching.
  assign bus.temp_addr = TADDR_W'(32'(y_q >> CELL_SHIFT) * CELLS_X
                                  + 32'(x_q >> CELL_SHIFT));

  // Next-state and datapath updates; colour is refetched only when x enters a new cell.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    clr_d   = clr_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    done_d  = done_q;
    rd      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.inter_start) begin
          x_d     = '0;
          y_d     = Y_FIRST;
          done_d  = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd      = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        clr_d   = band_clr;
        addr_d  = pixel_addr(x_q, y_q, H_RES);
        sel_d   = 1'b1;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (bus.comp_flag) begin
          sel_d = 1'b0;
          if (x_q < X_LAST) begin
            x_d     = x_q + 16'd1;
            state_d = ST_NEXT;
          end else if (y_next < Y_LIMIT) begin
            x_d     = '0;
            y_d     = y_next[15:0];
            state_d = ST_NEXT;
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_NEXT: begin
        if (x_q[CELL_SHIFT-1:0] == '0) begin
          state_d = ST_FETCH;
        end else begin
          addr_d  = pixel_addr(x_q, y_q, H_RES);
          sel_d   = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      clr_q   <= '0;
      addr_q  <= '0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      clr_q   <= clr_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  assign bus.temp_rd      = rd;
  assign bus.inter_select = sel_q;
  assign bus.inter_done   = done_q;
  assign bus.vga_addr     = addr_q;
  assign bus.vga_pxl_clr  = {24'h0, clr_q};

endmodule
